seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked ALU for the next-generation SCPU execute stage.
- Keeps the existing 12 single-cycle operation encodings and flags.
- Adds iterative multi-cycle multiply and unsigned divide/remainder.
- Adds a registered, back-pressurable result port so the pipeline can stall on long ops.
- Sits between the ID/EX register and the EX/MEM register; the control unit drives in_valid/alu_control, and writeback consumes out_* on out_valid & out_ready.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, ≥8.
- SHW, $clog2(WIDTH), shift-amount width; localparam, derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort: drops any in-flight op and the held result.
- in_valid  input  1  operands/op are valid this cycle.
- in_ready  output  1  block accepts an op this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_control  input  4  operation select.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- alu_result  output  WIDTH  result.
- zero  output  1  alu_result == 0.
- cout  output  1  carry out.
- overflow  output  1  signed overflow.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, out_valid=0, alu_result=0, zero=1, cout=0, overflow=0, in_ready=0 while rst high.
  - Iteration counter and working registers are cleared.
- Accept: an op is accepted on a clk edge where in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
  - a, b and alu_control are sampled only at accept.
- Single-cycle op encodings:
  - 0000 ADD.
  - 0001 SUB.
  - 0010 NOT A.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 SLT, signed a<b → 1 else 0.
  - 0111 EQU, a==b → 1 else 0.
  - 1000 SLL.
  - 1001 SLTU, unsigned a<b → 1 else 0.
  - 1010 SRL.
  - 1011 SRA.
  - Result is registered; out_valid rises on the edge after accept (latency 1). Back-to-back accepts give one result per cycle.
- Arithmetic (WIDTH+1-bit internal sum):
  - ADD: cout = bit WIDTH of a+b; overflow = (a[MSB]==b[MSB]) & (res[MSB]!=a[MSB]).
  - SUB/SLT/SLTU/EQU: compute a+~b+1; cout = carry (1 means no borrow); overflow = (a[MSB]!=b[MSB]) & (res[MSB]!=a[MSB]).
  - SLT flag outputs are those of the subtraction. EQU forces overflow=0.
  - Logic ops and shifts: cout=0, overflow=0.
  - Shifts use b[SHW-1:0] only.
- Multi-cycle ops:
  - 1100 MUL: low WIDTH bits of a*b.
  - 1101 MULHU: high WIDTH bits of the unsigned a*b.
  - 1110 DIVU: unsigned quotient.
  - 1111 REMU: unsigned remainder.
  - Accept → state BUSY. Shift-add multiply, or restoring divide, one bit per cycle, counter WIDTH-1 down to 0.
  - On the edge where the counter reaches 0 → result loaded, out_valid=1, state=IDLE. Latency = WIDTH+1 edges from accept (33 at WIDTH=32).
  - in_ready=0 throughout BUSY.
  - Flags: zero from result; cout=0; overflow=0.
  - Divide by zero: DIVU → all ones, REMU → a. Timing is identical, with no early exit.
- Output hold: while out_valid & !out_ready, alu_result and the flags are frozen and no new op is accepted.
  - On out_ready with no new accept → out_valid falls next edge.
  - An accept and a drain in the same cycle are allowed: the new single-cycle result replaces the old one with out_valid staying 1.
- FSM transitions:
  - IDLE→IDLE: single-cycle accept.
  - IDLE→BUSY: multi-cycle accept.
  - BUSY→IDLE: count done, or flush.
- Flush:
  - Next edge: state=IDLE, out_valid=0; outputs keep their last values.
  - Flush has priority over accept and over completion in the same cycle.
- Reset mid-operation: BUSY is abandoned immediately (asynchronously) and no result is produced.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 → after 1 cycle: out_valid=1, alu_result=0x80000000, overflow=1, cout=0, zero=0.
- SUB a=5, b=5 → alu_result=0, zero=1, cout=1, overflow=0. Then SLTU a=1, b=0xFFFFFFFF → 1, and SLT with the same operands → 0.
- MUL a=7, b=0xFFFFFFFD → 0xFFFFFFEB after exactly 33 edges, with in_ready=0 for 32 cycles. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- DIVU 100/7 → 14, REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with latency 33.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD 3+4 → alu_result stays 7, in_ready=0. Release out_ready while presenting XOR → the next result follows with no bubble.
- Assert rst at cycle 10 of a DIVU, then flush at cycle 5 of a second DIVU → out_valid stays 0, state IDLE, in_ready=1 the next cycle, and no stale result appears.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arithmetic ops plus iterative
// shift-add multiply and restoring unsigned divide, with a back-pressurable result register.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mop_q, mop_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             accept_s, multi_s, done_s, sub_s, add_ovf_s, sub_ovf_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_cout_s, sc_ovf_s;
  logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] acc_nx_s, mq_nx_s;

  assign in_ready   = (state_q == IDLE) & (!valid_q | out_ready) & !flush & !rst;
  assign accept_s   = in_valid & in_ready;
  assign multi_s    = (alu_control[3:2] == 2'b11);
  assign done_s     = (state_q == BUSY) & (cnt_q == {SHW{1'b0}});
  assign out_valid  = valid_q;
  assign alu_result = res_q;
  assign zero       = zero_q;
  assign cout       = cout_q;
  assign overflow   = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {SHW{1'b0}};
      mop_q   <= 2'b00;
      acc_q   <= {WIDTH{1'b0}};
      mq_q    <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      zero_q  <= 1'b1;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && multi_s) state_d = BUSY;
        else                     state_d = IDLE;
      end
      BUSY: begin
        if (flush || done_s) state_d = IDLE;
        else                 state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ops share one adder; everything except ADD computes a + ~b + 1.
  always_comb begin
    sub_s     = (alu_control != 4'b0000);
    sum_s     = {1'b0, a} + {1'b0, (sub_s ? ~b : b)} + {{WIDTH{1'b0}}, sub_s};
    add_ovf_s = (a[MSB] == b[MSB]) & (sum_s[MSB] != a[MSB]);
    sub_ovf_s = (a[MSB] != b[MSB]) & (sum_s[MSB] != a[MSB]);
    sc_res_s  = {WIDTH{1'b0}};
    sc_cout_s = 1'b0;
    sc_ovf_s  = 1'b0;
    case (alu_control)
      4'b0000: begin sc_res_s = sum_s[MSB:0]; sc_cout_s = sum_s[WIDTH]; sc_ovf_s = add_ovf_s; end
      4'b0001: begin sc_res_s = sum_s[MSB:0]; sc_cout_s = sum_s[WIDTH]; sc_ovf_s = sub_ovf_s; end
      4'b0010: sc_res_s = ~a;
      4'b0011: sc_res_s = a & b;
      4'b0100: sc_res_s = a | b;
      4'b0101: sc_res_s = a ^ b;
      4'b0110: begin
        sc_res_s  = {{(WIDTH-1){1'b0}}, sum_s[MSB] ^ sub_ovf_s};
        sc_cout_s = sum_s[WIDTH];
        sc_ovf_s  = sub_ovf_s;
      end
      4'b0111: begin sc_res_s = {{(WIDTH-1){1'b0}}, (a == b)}; sc_cout_s = sum_s[WIDTH]; end
      4'b1000: sc_res_s = a << b[SHW-1:0];
      4'b1001: begin
        sc_res_s  = {{(WIDTH-1){1'b0}}, ~sum_s[WIDTH]};
        sc_cout_s = sum_s[WIDTH];
        sc_ovf_s  = sub_ovf_s;
      end
      4'b1010: sc_res_s = a >> b[SHW-1:0];
      4'b1011: sc_res_s = $signed(a) >>> b[SHW-1:0];
      default: sc_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step: acc:mq is the product (shifting right) or remainder:quotient (shifting left).
  always_comb begin
    mul_sum_s  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_q, mq_q[MSB]};
    div_diff_s = div_sh_s - {1'b0, opb_q};
    div_ge_s   = (div_sh_s >= {1'b0, opb_q});
    if (!mop_q[1]) begin
      acc_nx_s = mul_sum_s[WIDTH:1];
      mq_nx_s  = {mul_sum_s[0], mq_q[MSB:1]};
    end else if (div_ge_s) begin
      acc_nx_s = div_diff_s[MSB:0];
      mq_nx_s  = {mq_q[MSB-1:0], 1'b1};
    end else begin
      acc_nx_s = div_sh_s[MSB:0];
      mq_nx_s  = {mq_q[MSB-1:0], 1'b0};
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opb_d   = opb_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (state_q == BUSY) begin
      acc_d = acc_nx_s;
      mq_d  = mq_nx_s;
      cnt_d = cnt_q - CNT_ONE;
      if (done_s) begin
        res_d   = mop_q[0] ? acc_nx_s : mq_nx_s;
        zero_d  = ((mop_q[0] ? acc_nx_s : mq_nx_s) == {WIDTH{1'b0}});
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        valid_d = 1'b1;
      end else begin
        valid_d = valid_q;
      end
    end else if (accept_s && multi_s) begin
      mop_d   = alu_control[1:0];
      cnt_d   = {SHW{1'b1}};
      acc_d   = {WIDTH{1'b0}};
      mq_d    = a;
      opb_d   = b;
      valid_d = 1'b0;
    end else if (accept_s) begin
      res_d   = sc_res_s;
      zero_d  = (sc_res_s == {WIDTH{1'b0}});
      cout_d  = sc_cout_s;
      ovf_d   = sc_ovf_s;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written backpressure / reset / flush sequences.
module tb_seq_alu;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  alu_control = 4'd0;
  logic        in_ready, out_valid, zero, cout, overflow;
  logic [31:0] alu_result;

  int total = 0;
  int bad = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] r;
    logic        z;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic oor(input longint v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  // Reference: plain wide arithmetic on the operands.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c,
                                output logic [31:0] r, output logic co, output logic ov);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    longint unsigned prod = ux * uy;
    longint unsigned usum = ux + uy;
    longint sra;
    r = 32'd0; co = 1'b0; ov = 1'b0;
    case (c)
      4'd0:  begin r = x + y; co = usum > 64'hFFFF_FFFF; ov = oor(sx + sy); end
      4'd1:  begin r = x - y; co = ux >= uy; ov = oor(sx - sy); end
      4'd2:  r = ~x;
      4'd3:  r = x & y;
      4'd4:  r = x | y;
      4'd5:  r = x ^ y;
      4'd6:  begin r = {31'd0, sx < sy}; co = ux >= uy; ov = oor(sx - sy); end
      4'd7:  begin r = {31'd0, x == y}; co = ux >= uy; end
      4'd8:  r = x << y[4:0];
      4'd9:  begin r = {31'd0, ux < uy}; co = ux >= uy; ov = oor(sx - sy); end
      4'd10: r = x >> y[4:0];
      4'd11: begin sra = sx >>> y[4:0]; r = sra[31:0]; end
      4'd12: r = prod[31:0];
      4'd13: r = prod[63:32];
      4'd14: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      4'd15: r = (y == 32'd0) ? x : x % y;
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op from IDLE with out_ready high; report result, latency in edges, busy cycles.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c,
                        output logic [31:0] r, output logic z, output logic co, output logic ov,
                        output int lat, output int busy);
    a = x; b = y; alu_control = c; in_valid = 1'b1; out_ready = 1'b1;
    busy = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    r = alu_result; z = zero; co = cout; ov = overflow;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] c, input logic [31:0] er, input logic ez,
                          input logic eco, input logic eov);
    logic [31:0] r;
    logic z, co, ov;
    int lat, busy;
    bit multi;
    multi = (c >= 4'd12);
    run_op(x, y, c, r, z, co, ov, lat, busy);
    chk({tag, " result"}, r, er);
    chk({tag, " zero"}, {31'd0, z}, {31'd0, ez});
    chk({tag, " cout"}, {31'd0, co}, {31'd0, eco});
    chk({tag, " overflow"}, {31'd0, ov}, {31'd0, eov});
    chk({tag, " latency"}, lat, multi ? 32'd33 : 32'd1);
    chk({tag, " busy cycles"}, busy, multi ? 32'd32 : 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners[0] = 32'd0;
    corners[1] = 32'd1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h8000_0000;
    corners[5] = $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    logic [31:0] x, y, er;
    logic [3:0] c;
    logic eco, eov;
    int cnt;

    tbl[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  32'h8000_0000, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{32'h0000_0005, 32'h0000_0005, 4'd1,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{32'h0000_0001, 32'hFFFF_FFFF, 4'd9,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0001, 32'hFFFF_FFFF, 4'd6,  32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32'h0000_1234, 32'h0000_1234, 4'd7,  32'h0000_0001, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'h0000_0021, 4'd11, 32'hC000_0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h0000_0001, 32'h0000_003F, 4'd8,  32'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h8000_0000, 32'h0000_0001, 4'd1,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{32'h0000_0007, 32'hFFFF_FFFD, 4'd12, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'd100,       32'd7,         4'd14, 32'd14,        1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'd100,       32'd7,         4'd15, 32'd2,         1'b0, 1'b0, 1'b0};
    tbl[12] = '{32'd5,         32'd0,         4'd14, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    // reset state
    #12;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset result", alu_result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd1);
    chk("reset cout", {31'd0, cout}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++)
      check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].z, tbl[i].co, tbl[i].ov);
    check_op("remu by zero", 32'd5, 32'd0, 4'd15, 32'd5, 1'b0, 1'b0, 1'b0);

    // randomized single-cycle then multi-cycle ops
    for (int i = 0; i < 250; i++) begin
      x = pick_operand(); y = pick_operand(); c = 4'($urandom_range(0, 11));
      model(x, y, c, er, eco, eov);
      check_op($sformatf("rand op%0d", c), x, y, c, er, er == 32'd0, eco, eov);
    end
    for (int i = 0; i < 30; i++) begin
      x = pick_operand(); y = ($urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
      c = 4'($urandom_range(12, 15));
      model(x, y, c, er, eco, eov);
      check_op($sformatf("rand op%0d", c), x, y, c, er, er == 32'd0, eco, eov);
    end

    // back-to-back single-cycle stream: one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x = pick_operand(); y = pick_operand(); c = 4'($urandom_range(0, 11));
      a = x; b = y; alu_control = c; in_valid = 1'b1;
      model(x, y, c, er, eco, eov);
      @(posedge clk); #1;
      chk("stream valid", {31'd0, out_valid}, 32'd1);
      chk("stream result", alu_result, er);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream drained", {31'd0, out_valid}, 32'd0);

    // backpressure: ADD 3+4 held for 5 cycles, a competing SUB must not be accepted
    a = 32'd3; b = 32'd4; alu_control = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd9; alu_control = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("hold result", alu_result, 32'd7);
      chk("hold valid", {31'd0, out_valid}, 32'd1);
      chk("hold in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("hold result end", alu_result, 32'd7);
    out_ready = 1'b1; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; alu_control = 4'd5;
    #1;
    chk("release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("no-bubble valid", {31'd0, out_valid}, 32'd1);
    chk("no-bubble xor", alu_result, 32'h0FF0_0FF0);
    @(posedge clk); #1;
    chk("xor drained", {31'd0, out_valid}, 32'd0);

    // reset during cycle 10 of a DIVU
    a = 32'd100; b = 32'd7; alu_control = 4'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid-div reset valid", {31'd0, out_valid}, 32'd0);
    chk("mid-div reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid-div reset result", alu_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after reset in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("no result after reset", cnt, 32'd0);

    // flush at cycle 5 of a DIVU; outputs keep the previous result (7)
    check_op("pre-flush add", 32'd3, 32'd4, 4'd0, 32'd7, 1'b0, 1'b0, 1'b0);
    a = 32'd200; b = 32'd3; alu_control = 4'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    chk("flush blocks in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush keeps result", alu_result, 32'd7);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("no stale result after flush", cnt, 32'd0);

    // flush in the completion cycle wins over the result load
    a = 32'd200; b = 32'd3; alu_control = 4'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush at done valid", {31'd0, out_valid}, 32'd0);
    chk("flush at done result", alu_result, 32'd7);

    // flush beats an accept in IDLE
    a = 32'd1; b = 32'd1; alu_control = 4'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush vs accept valid", {31'd0, out_valid}, 32'd0);
    chk("flush vs accept result", alu_result, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
